// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue and
// credit-limited sequential fetch; redirects flush and drop stale reads.
module ifu_prefetch #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
    parameter int              DEPTH       = 4,
    parameter logic [XLEN-1:0] EBREAK_WORD = 32'h0010_0073
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            ifu_valid,
    input  logic            idu_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ebreak
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] ent_pc_q    [DEPTH];
    logic [XLEN-1:0] ent_instr_q [DEPTH];

    logic [CW:0]     credit;
    logic [XLEN-1:0] target;
    logic            issue;
    logic            keep;
    logic            pop;

    assign credit = {1'b0, count_q} + {1'b0, outst_q};
    assign target = redirect_pc & ~XLEN'(3);

    assign mem_req_valid = rst && !redirect_valid
                        && (credit < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;
    assign issue         = mem_req_valid && mem_req_ready;

    assign ifu_valid = rst && !redirect_valid && (count_q != '0);
    assign pc        = ent_pc_q[head_q];
    assign instr     = ent_instr_q[head_q];
    assign ebreak    = ifu_valid && (instr == EBREAK_WORD);
    assign pop       = ifu_valid && idu_ready;

    // Non-dropped responses are sequential from the last redirect/reset,
    // so a running response PC replaces a separate PC FIFO.
    assign keep = rst && !redirect_valid && mem_resp_valid
               && (drop_q == '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(issue) - CW'(mem_resp_valid);
        if (redirect_valid) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            drop_d     = drop_q + outst_q - CW'(mem_resp_valid);
        end else begin
            if (issue)
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (mem_resp_valid && drop_q != '0)
                drop_d = drop_q - CW'(1);
            if (keep) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                tail_d    = tail_q + AW'(1);
            end
            if (pop)
                head_d = head_q + AW'(1);
            count_d = count_q + CW'(keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            ent_pc_q[tail_q]    <= resp_pc_q;
            ent_instr_q[tail_q] <= mem_resp_data;
        end
    end

endmodule
